// File: rtl/process_scheduler.sv
// Time-slice scheduler sharing one program counter between NUM_PROC user programs and the OS.
// Counts retired instructions per quantum, saves relative resume addresses, dispatches round-robin.
module process_scheduler #(
  parameter int NUM_PROC    = 4,
  parameter int PID_W       = 2,
  parameter int QUANTUM     = 5,
  parameter int PROG_STRIDE = 1000,
  parameter int ADDR_W      = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stop,
  input  logic                inst_valid,
  input  logic                end_program,
  input  logic [ADDR_W-1:0]   pc_next,
  input  logic                os_ack,
  input  logic                launch,
  input  logic [PID_W-1:0]    launch_pid,
  input  logic [ADDR_W-1:0]   launch_pc,
  output logic                load_pc,
  output logic [ADDR_W-1:0]   resume_pc,
  output logic                preempt,
  output logic                os_mode,
  output logic [PID_W-1:0]    cur_pid,
  output logic [NUM_PROC-1:0] ready,
  output logic                all_done
);

  localparam int QW = (QUANTUM < 2) ? 1 : $clog2(QUANTUM + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_RUN, ST_OS} state_t;

  state_t               state_reg, state_next;
  logic [QW-1:0]        qcount_reg;
  logic [PID_W-1:0]     cur_pid_reg;
  logic [ADDR_W-1:0]    resume_pc_reg;
  logic [NUM_PROC-1:0]  ready_reg;
  logic                 all_done_reg;
  logic                 load_pc_reg, load_pc_next;
  logic                 preempt_reg, preempt_next;
  logic                 first_reg;
  logic [ADDR_W-1:0]    saved_pc_reg [NUM_PROC];
  logic [ADDR_W-1:0]    base_tbl [NUM_PROC];

  logic                 quantum_save, prog_end, all_done_set;
  logic [PID_W-1:0]     next_pid, scan_idx;
  int                   scan_start;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PROC; gi++) begin : g_base
      assign base_tbl[gi] = ADDR_W'((gi + 1) * PROG_STRIDE);
    end
  endgenerate

  // Round-robin pick: lowest offset from the scan start wins, so iterate from the far end down.
  always_comb begin
    scan_start = first_reg ? 0 : (int'(cur_pid_reg) + 1) % NUM_PROC;
    next_pid   = cur_pid_reg;
    scan_idx   = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      scan_idx = PID_W'((scan_start + i) % NUM_PROC);
      if (ready_reg[scan_idx]) next_pid = scan_idx;
    end
  end

  always_comb begin
    state_next   = state_reg;
    load_pc_next = 1'b0;
    preempt_next = 1'b0;
    quantum_save = 1'b0;
    prog_end     = 1'b0;
    all_done_set = 1'b0;
    case (state_reg)
      ST_IDLE: if (|ready_reg) state_next = ST_DISPATCH;
      ST_DISPATCH: begin
        state_next   = ST_RUN;
        load_pc_next = 1'b1;
      end
      ST_RUN: begin
        if (!stop) begin
          if (end_program) begin
            prog_end     = 1'b1;
            preempt_next = 1'b1;
            state_next   = ST_OS;
          end else if (inst_valid && qcount_reg == QW'(QUANTUM - 1)) begin
            quantum_save = 1'b1;
            preempt_next = 1'b1;
            state_next   = ST_OS;
          end
        end
      end
      ST_OS: begin
        if (os_ack) begin
          if (|ready_reg) begin
            state_next = ST_DISPATCH;
          end else begin
            state_next   = ST_IDLE;
            all_done_set = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      qcount_reg    <= '0;
      cur_pid_reg   <= '0;
      resume_pc_reg <= '0;
      ready_reg     <= '0;
      all_done_reg  <= 1'b0;
      load_pc_reg   <= 1'b0;
      preempt_reg   <= 1'b0;
      first_reg     <= 1'b1;
      for (int i = 0; i < NUM_PROC; i++) saved_pc_reg[i] <= '0;
    end else begin
      state_reg   <= state_next;
      load_pc_reg <= load_pc_next;
      preempt_reg <= preempt_next;
      if (state_reg == ST_DISPATCH) begin
        cur_pid_reg   <= next_pid;
        resume_pc_reg <= base_tbl[next_pid] + saved_pc_reg[next_pid];
        qcount_reg    <= '0;
        first_reg     <= 1'b0;
      end else if (state_reg == ST_RUN && !stop && inst_valid && !end_program) begin
        qcount_reg <= qcount_reg + QW'(1);
      end
      if (prog_end) ready_reg[cur_pid_reg] <= 1'b0;
      if (quantum_save) saved_pc_reg[cur_pid_reg] <= pc_next - base_tbl[cur_pid_reg];
      if (all_done_set) all_done_reg <= 1'b1;
      // Launch is written last so it overrides a same-cycle end or quantum save on its slot.
      if (launch) begin
        ready_reg[launch_pid]    <= 1'b1;
        saved_pc_reg[launch_pid] <= launch_pc;
        all_done_reg             <= 1'b0;
      end
    end
  end

  assign load_pc   = load_pc_reg;
  assign preempt   = preempt_reg;
  assign resume_pc = resume_pc_reg;
  assign os_mode   = (state_reg == ST_OS);
  assign cur_pid   = cur_pid_reg;
  assign ready     = ready_reg;
  assign all_done  = all_done_reg;

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a behavioural scheduler model.
module tb_process_scheduler;
  localparam int N = 4;
  localparam int Q = 5;
  localparam int S = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stop = 1'b0, inst_valid = 1'b0, end_program = 1'b0, os_ack = 1'b0, launch = 1'b0;
  logic [1:0]  launch_pid = '0;
  logic [31:0] pc_next = '0, launch_pc = '0;
  logic        load_pc, preempt, os_mode, all_done;
  logic [31:0] resume_pc;
  logic [1:0]  cur_pid;
  logic [3:0]  ready;

  process_scheduler #(.NUM_PROC(N), .PID_W(2), .QUANTUM(Q), .PROG_STRIDE(S), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .stop(stop), .inst_valid(inst_valid),
    .end_program(end_program), .pc_next(pc_next), .os_ack(os_ack), .launch(launch),
    .launch_pid(launch_pid), .launch_pc(launch_pc), .load_pc(load_pc), .resume_pc(resume_pc),
    .preempt(preempt), .os_mode(os_mode), .cur_pid(cur_pid), .ready(ready), .all_done(all_done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  // Model: phase 0 idle, 1 choosing next program, 2 program running, 3 OS owns the PC.
  int          m_phase = 0;
  bit          m_first = 1'b1;
  int          m_cur = 0;
  int          m_retired = 0;
  logic [3:0]  m_ready = '0;
  bit          m_done = 1'b0, m_load = 1'b0, m_pre = 1'b0;
  logic [31:0] m_resume = '0;
  logic [31:0] m_saved [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] r0;
    int start, pick;
    if (!reset) begin
      m_phase = 0; m_first = 1'b1; m_cur = 0; m_retired = 0; m_ready = '0;
      m_done = 1'b0; m_load = 1'b0; m_pre = 1'b0; m_resume = '0;
      for (int i = 0; i < N; i++) m_saved[i] = '0;
    end else begin
      r0 = m_ready;
      m_load = 1'b0;
      m_pre = 1'b0;
      case (m_phase)
        0: if (r0 != 0) m_phase = 1;
        1: begin
          start = m_first ? 0 : (m_cur + 1) % N;
          pick = -1;
          for (int k = 0; k < N; k++)
            if (pick < 0 && r0[(start + k) % N]) pick = (start + k) % N;
          m_cur = pick;
          m_resume = 32'((pick + 1) * S) + m_saved[pick];
          m_load = 1'b1;
          m_retired = 0;
          m_first = 1'b0;
          m_phase = 2;
        end
        2: if (!stop) begin
          if (end_program) begin
            m_ready[m_cur] = 1'b0;
            m_pre = 1'b1;
            m_phase = 3;
          end else if (inst_valid) begin
            m_retired++;
            if (m_retired == Q) begin
              m_saved[m_cur] = pc_next - 32'((m_cur + 1) * S);
              m_pre = 1'b1;
              m_phase = 3;
            end
          end
        end
        default: if (os_ack) begin
          if (r0 != 0) m_phase = 1;
          else begin
            m_phase = 0;
            m_done = 1'b1;
          end
        end
      endcase
      if (launch) begin
        m_ready[launch_pid] = 1'b1;
        m_saved[launch_pid] = launch_pc;
        m_done = 1'b0;
      end
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      chk("load_pc", {31'b0, load_pc}, {31'b0, m_load});
      chk("preempt", {31'b0, preempt}, {31'b0, m_pre});
      chk("os_mode", {31'b0, os_mode}, {31'b0, m_phase == 3});
      chk("cur_pid", {30'b0, cur_pid}, 32'(m_cur));
      chk("ready", {28'b0, ready}, {28'b0, m_ready});
      chk("all_done", {31'b0, all_done}, {31'b0, m_done});
      chk("resume_pc", resume_pc, m_resume);
      chk("pulse_excl", {31'b0, load_pc & preempt}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    check_en = 1'b1;
    @(negedge clock);
    #1;
    inst_valid = 1'b0; end_program = 1'b0; os_ack = 1'b0; launch = 1'b0;
  endtask

  task automatic do_launch(input int pid, input int pc);
    launch = 1'b1; launch_pid = 2'(pid); launch_pc = 32'(pc);
    tick();
  endtask

  task automatic retire(input int pc);
    inst_valid = 1'b1; pc_next = 32'(pc);
    tick();
  endtask

  task automatic ack();
    os_ack = 1'b1;
    tick();
  endtask

  task automatic wait_load(input string name, input int exp_pc, input int exp_pid);
    int n = 0;
    while (!load_pc && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_load_seen"}, {31'b0, load_pc}, 32'd1);
    chk({name, "_resume"}, resume_pc, 32'(exp_pc));
    chk({name, "_pid"}, {30'b0, cur_pid}, 32'(exp_pid));
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_saved[i] = '0;
    tick(); tick();
    reset = 1'b1;

    // Reset in the middle of a running quantum
    do_launch(2, 0);
    wait_load("mid_run", 3000, 2);
    for (int i = 1; i <= 3; i++) retire(3000 + i);
    reset = 1'b0;
    tick();
    chk("rst_ready", {28'b0, ready}, 32'd0);
    chk("rst_pid", {30'b0, cur_pid}, 32'd0);
    chk("rst_outs", {28'b0, load_pc, preempt, os_mode, all_done}, 32'd0);
    chk("rst_resume", resume_pc, 32'd0);
    reset = 1'b1;

    // Two programs alternate, pid0 resumes where it left off
    do_launch(0, 0);
    do_launch(1, 0);
    wait_load("rr0", 1000, 0);
    for (int i = 1; i <= 5; i++) retire(1000 + i);
    chk("q0_preempt", {31'b0, preempt}, 32'd1);
    ack();
    wait_load("rr1", 2000, 1);
    for (int i = 1; i <= 5; i++) retire(2000 + i);
    chk("q1_preempt", {31'b0, preempt}, 32'd1);
    ack();
    wait_load("rr_wrap", 1005, 0);

    // stop freezes the quantum count
    retire(1006);
    retire(1007);
    stop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      retire(1099);
      chk("stop_no_preempt", {31'b0, preempt}, 32'd0);
    end
    stop = 1'b0;
    retire(1008);
    retire(1009);
    chk("q_not_yet", {31'b0, preempt}, 32'd0);
    retire(1010);
    chk("q_after_stop", {31'b0, preempt}, 32'd1);

    // Programs end one by one until nothing is ready
    ack();
    wait_load("p1_again", 2005, 1);
    end_program = 1'b1;
    tick();
    chk("end1_preempt", {31'b0, preempt}, 32'd1);
    chk("end1_ready", {28'b0, ready}, 32'd1);
    ack();
    wait_load("p0_again", 1010, 0);
    end_program = 1'b1;
    tick();
    chk("end0_ready", {28'b0, ready}, 32'd0);
    ack();
    chk("all_done_set", {31'b0, all_done}, 32'd1);
    chk("idle_os_mode", {31'b0, os_mode}, 32'd0);
    do_launch(3, 7);
    chk("all_done_clr", {31'b0, all_done}, 32'd0);
    wait_load("p3", 4007, 3);

    // Launch beats end_program on the same slot
    do_launch(1, 0);
    end_program = 1'b1;
    tick();
    ack();
    wait_load("p1_fresh", 2000, 1);
    end_program = 1'b1;
    launch = 1'b1; launch_pid = 2'd1; launch_pc = 32'd20;
    tick();
    chk("relaunch_ready", {28'b0, ready}, 32'd2);
    ack();
    wait_load("p1_relaunch", 2020, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom % 400) != 0;
      stop        = ($urandom % 8) == 0;
      inst_valid  = ($urandom % 2) == 0;
      end_program = ($urandom % 16) == 0;
      os_ack      = ($urandom % 3) == 0;
      launch      = ($urandom % 20) == 0;
      launch_pid  = 2'($urandom % N);
      launch_pc   = $urandom_range(0, 500);
      pc_next     = 32'((m_cur + 1) * S) + $urandom_range(0, 99);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
